// File: rtl/llist_mq_fifo_pkg.sv
// llist_mq_fifo_pkg: shared FSM encoding and default sizing for the linked-list multi-queue fifo
package llist_mq_fifo_pkg;
  typedef enum logic {ST_INIT, ST_RUN} state_e;
  localparam int DWIDTH_DEF = 8;
  localparam int DEPTH_DEF = 16;
  localparam int NQ_DEF = 4;
  localparam int AWIDTH_DEF = $clog2(DEPTH_DEF);
  localparam int QWIDTH_DEF = $clog2(NQ_DEF);
  localparam int CWIDTH_DEF = $clog2(DEPTH_DEF) + 1;
endpackage

// File: rtl/llist_mem.sv
// llist_mem: register array with one synchronous write port and two asynchronous read ports
//  clk: write clock; we/waddr/wdata: write port; raddr0/rdata0, raddr1/rdata1: combinational reads
module llist_mem #(
  parameter int W = 8,
  parameter int DEPTH = 16,
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic [AWIDTH-1:0] raddr0,
  output logic [W-1:0]      rdata0,
  input  logic [AWIDTH-1:0] raddr1,
  output logic [W-1:0]      rdata1
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end
  assign rdata0 = mem_q[raddr0];
  assign rdata1 = mem_q[raddr1];
endmodule

// File: rtl/llist_mq_fifo.sv
// llist_mq_fifo: NQ logical fifos sharing one DEPTH-entry pool, linked through a next-pointer array
//  clk/reset: clock, async active-high reset (restarts free-list build)
//  din/push/push_q: push word into queue push_q; pop/pop_q: pop queue pop_q, dout shows its head
//  rdy: per-queue non-empty; not_full: push acceptable now; free_cnt: unallocated entries
//  init_done: free list built; ovf_err/udf_err: sticky rejected push/pop
module llist_mq_fifo
  import llist_mq_fifo_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int NQ = NQ_DEF,
  parameter int QWIDTH = QWIDTH_DEF,
  parameter int CWIDTH = CWIDTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] din,
  input  logic              push,
  input  logic [QWIDTH-1:0] push_q,
  input  logic              pop,
  input  logic [QWIDTH-1:0] pop_q,
  output logic [DWIDTH-1:0] dout,
  output logic [NQ-1:0]     rdy,
  output logic              not_full,
  output logic [CWIDTH-1:0] free_cnt,
  output logic              init_done,
  output logic              ovf_err,
  output logic              udf_err
);
  state_e state_q, state_d;
  logic [AWIDTH-1:0] init_cnt_q, init_cnt_d;
  logic [AWIDTH-1:0] free_head_q, free_head_d;
  logic [CWIDTH-1:0] free_cnt_q, free_cnt_d;
  logic ovf_q, ovf_d, udf_q, udf_d;
  logic [AWIDTH-1:0] head_q [NQ];
  logic [AWIDTH-1:0] head_d [NQ];
  logic [AWIDTH-1:0] tail_q [NQ];
  logic [AWIDTH-1:0] tail_d [NQ];
  logic [CWIDTH-1:0] qcnt_q [NQ];
  logic [CWIDTH-1:0] qcnt_d [NQ];
  logic nxt_we;
  logic [AWIDTH-1:0] nxt_wa, nxt_wd, nxt_free, nxt_pop;
  logic [AWIDTH-1:0] pop_addr, push_addr;
  logic [DWIDTH-1:0] data_unused;
  logic pop_ok, push_ok, push_restart;
  assign init_done = (state_q == ST_RUN);
  always_comb begin
    for (int q = 0; q < NQ; q++) rdy[q] = (qcnt_q[q] != '0) & init_done;
  end
  assign pop_ok = pop & rdy[pop_q];
  assign not_full = init_done & ((free_cnt_q != '0) | pop_ok);
  assign push_ok = push & not_full;
  assign pop_addr = head_q[pop_q];
  // a same-cycle pop hands its entry straight to the push, bypassing the free list
  assign push_addr = pop_ok ? pop_addr : free_head_q;
  // target queue restarts from scratch when empty, or when its only entry is popped this cycle
  assign push_restart = (qcnt_q[push_q] == '0) |
                        (pop_ok & (pop_q == push_q) & (qcnt_q[push_q] == CWIDTH'(1)));
  assign free_cnt = free_cnt_q;
  assign ovf_err = ovf_q;
  assign udf_err = udf_q;
  llist_mem #(.W(AWIDTH), .DEPTH(DEPTH), .AWIDTH(AWIDTH)) u_nxt (
    .clk(clk), .we(nxt_we), .waddr(nxt_wa), .wdata(nxt_wd),
    .raddr0(free_head_q), .rdata0(nxt_free),
    .raddr1(pop_addr), .rdata1(nxt_pop)
  );
  llist_mem #(.W(DWIDTH), .DEPTH(DEPTH), .AWIDTH(AWIDTH)) u_data (
    .clk(clk), .we(push_ok), .waddr(push_addr), .wdata(din),
    .raddr0(pop_addr), .rdata0(dout),
    .raddr1(free_head_q), .rdata1(data_unused)
  );
  always_comb begin
    state_d = state_q;
    init_cnt_d = init_cnt_q;
    free_head_d = free_head_q;
    free_cnt_d = free_cnt_q;
    ovf_d = ovf_q | (push & init_done & ~not_full);
    udf_d = udf_q | (pop & init_done & ~rdy[pop_q]);
    head_d = head_q;
    tail_d = tail_q;
    qcnt_d = qcnt_q;
    nxt_we = 1'b0;
    nxt_wa = '0;
    nxt_wd = '0;
    if (state_q == ST_INIT) begin
      nxt_we = 1'b1;
      nxt_wa = init_cnt_q;
      nxt_wd = init_cnt_q + 1'b1;
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == AWIDTH'(DEPTH - 1)) begin
        state_d = ST_RUN;
        free_cnt_d = CWIDTH'(DEPTH);
      end
    end
    if (pop_ok & ~push_ok) begin
      free_head_d = pop_addr;
      free_cnt_d = free_cnt_q + 1'b1;
      nxt_we = 1'b1;
      nxt_wa = pop_addr;
      nxt_wd = free_head_q;
    end
    if (push_ok & ~pop_ok) begin
      free_head_d = nxt_free;
      free_cnt_d = free_cnt_q - 1'b1;
    end
    if (pop_ok) begin
      head_d[pop_q] = nxt_pop;
      qcnt_d[pop_q] = qcnt_q[pop_q] - 1'b1;
    end
    if (push_ok) begin
      if (push_restart) head_d[push_q] = push_addr;
      else begin
        nxt_we = 1'b1;
        nxt_wa = tail_q[push_q];
        nxt_wd = push_addr;
      end
      tail_d[push_q] = push_addr;
      qcnt_d[push_q] = qcnt_d[push_q] + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      init_cnt_q <= '0;
      free_head_q <= '0;
      free_cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      for (int q = 0; q < NQ; q++) begin
        head_q[q] <= '0;
        tail_q[q] <= '0;
        qcnt_q[q] <= '0;
      end
    end else begin
      state_q <= state_d;
      init_cnt_q <= init_cnt_d;
      free_head_q <= free_head_d;
      free_cnt_q <= free_cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      head_q <= head_d;
      tail_q <= tail_d;
      qcnt_q <= qcnt_d;
    end
  end
endmodule

// File: tb/tb_llist_mq_fifo.sv
// tb_llist_mq_fifo: directed table and sequence checks for the linked-list multi-queue fifo
module tb_llist_mq_fifo;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] din = '0;
  logic push = 1'b0;
  logic [1:0] push_q = '0;
  logic pop = 1'b0;
  logic [1:0] pop_q = '0;
  logic [7:0] dout;
  logic [3:0] rdy;
  logic not_full;
  logic [4:0] free_cnt;
  logic init_done, ovf_err, udf_err;
  int npass = 0;
  int ntot = 0;
  typedef struct {
    logic       push;
    logic [1:0] pq;
    logic [7:0] din;
    logic       pop;
    logic [1:0] oq;
    logic [1:0] cq;
    logic [3:0] rdy;
    logic [4:0] fc;
    logic       cd;
    logic [7:0] dv;
  } vec_t;
  vec_t tv [7];
  always #5 clk = ~clk;
  llist_mq_fifo dut (
    .clk(clk), .reset(reset), .din(din), .push(push), .push_q(push_q),
    .pop(pop), .pop_q(pop_q), .dout(dout), .rdy(rdy), .not_full(not_full),
    .free_cnt(free_cnt), .init_done(init_done), .ovf_err(ovf_err), .udf_err(udf_err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    push = 1'b0;
    pop = 1'b0;
    #1;
  endtask
  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (!init_done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    push = 1'b0;
    pop = 1'b0;
    #1;
    chk(name, n, 16);
  endtask
  initial begin
    tv[0] = '{1'b1, 2'd2, 8'hA1, 1'b0, 2'd0, 2'd2, 4'b0100, 5'd15, 1'b1, 8'hA1};
    tv[1] = '{1'b1, 2'd2, 8'hA2, 1'b0, 2'd0, 2'd2, 4'b0100, 5'd14, 1'b1, 8'hA1};
    tv[2] = '{1'b1, 2'd1, 8'hB1, 1'b0, 2'd0, 2'd1, 4'b0110, 5'd13, 1'b1, 8'hB1};
    tv[3] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'd2, 4'b0110, 5'd14, 1'b1, 8'hA2};
    tv[4] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'd1, 4'b0010, 5'd15, 1'b1, 8'hB1};
    tv[5] = '{1'b1, 2'd1, 8'h55, 1'b1, 2'd1, 2'd1, 4'b0010, 5'd15, 1'b1, 8'h55};
    tv[6] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd1, 4'b0000, 5'd16, 1'b0, 8'h00};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", rdy, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_free_cnt", free_cnt, 0);
    chk("rst_not_full", not_full, 0);
    @(negedge clk);
    reset = 1'b0;
    push = 1'b1;
    pop = 1'b1;
    pop_q = 2'd3;
    wait_init("init_cycles");
    chk("init_free_cnt", free_cnt, 16);
    chk("init_rdy", rdy, 0);
    chk("init_no_ovf", ovf_err, 0);
    chk("init_no_udf", udf_err, 0);
    pop = 1'b1;
    pop_q = 2'd3;
    step();
    chk("udf_set", udf_err, 1);
    chk("udf_free_cnt", free_cnt, 16);
    for (int i = 0; i < 7; i++) begin
      push = tv[i].push;
      push_q = tv[i].pq;
      din = tv[i].din;
      pop = tv[i].pop;
      pop_q = tv[i].oq;
      step();
      pop_q = tv[i].cq;
      #1;
      chk($sformatf("vec%0d_rdy", i), rdy, tv[i].rdy);
      chk($sformatf("vec%0d_free_cnt", i), free_cnt, tv[i].fc);
      if (tv[i].cd) chk($sformatf("vec%0d_dout", i), dout, tv[i].dv);
    end
    for (int i = 0; i < 16; i++) begin
      push = 1'b1;
      push_q = 2'd0;
      din = 8'(i);
      step();
      chk($sformatf("fill%0d_free_cnt", i), free_cnt, 15 - i);
    end
    chk("full_not_full", not_full, 0);
    chk("full_rdy", rdy, 4'b0001);
    push = 1'b1;
    push_q = 2'd3;
    din = 8'hC3;
    pop = 1'b1;
    pop_q = 2'd0;
    #1;
    chk("full_pop_not_full", not_full, 1);
    chk("full_pop_dout", dout, 8'h00);
    step();
    chk("swap_rdy", rdy, 4'b1001);
    chk("swap_free_cnt", free_cnt, 0);
    pop_q = 2'd3;
    #1;
    chk("swap_q3_dout", dout, 8'hC3);
    pop_q = 2'd0;
    #1;
    chk("swap_q0_dout", dout, 8'h01);
    push = 1'b1;
    push_q = 2'd2;
    din = 8'hEE;
    #1;
    chk("ovf_not_full", not_full, 0);
    step();
    chk("ovf_set", ovf_err, 1);
    chk("ovf_rdy", rdy, 4'b1001);
    chk("ovf_free_cnt", free_cnt, 0);
    chk("ovf_q0_dout", dout, 8'h01);
    chk("udf_sticky", udf_err, 1);
    pop = 1'b1;
    pop_q = 2'd3;
    step();
    chk("popq3_free_cnt", free_cnt, 1);
    chk("popq3_rdy", rdy, 4'b0001);
    for (int i = 1; i < 8; i++) begin
      pop = 1'b1;
      pop_q = 2'd0;
      #1;
      chk($sformatf("drain%0d_dout", i), dout, 8'(i));
      step();
    end
    chk("drain_free_cnt", free_cnt, 8);
    push = 1'b1;
    push_q = 2'd2;
    din = 8'h99;
    step();
    chk("nine_free_cnt", free_cnt, 7);
    chk("nine_rdy", rdy, 4'b0101);
    pop_q = 2'd0;
    #1;
    chk("nine_q0_dout", dout, 8'h08);
    chk("ovf_sticky", ovf_err, 1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_rdy", rdy, 0);
    chk("mid_rst_init_done", init_done, 0);
    chk("mid_rst_free_cnt", free_cnt, 0);
    chk("mid_rst_ovf", ovf_err, 0);
    chk("mid_rst_udf", udf_err, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_init("reinit_cycles");
    chk("reinit_free_cnt", free_cnt, 16);
    chk("reinit_rdy", rdy, 0);
    push = 1'b1;
    push_q = 2'd1;
    din = 8'h77;
    step();
    pop_q = 2'd1;
    #1;
    chk("post_rdy", rdy, 4'b0010);
    chk("post_dout", dout, 8'h77);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
